// File: rtl/fetch_unit.sv
// fetch_unit: single-slot instruction fetch stage with branch redirect and halt detection.
//
// Ports:
//   clk, rst_n       rising-edge clock; asynchronous active-low reset
//   start            pulse in IDLE that begins fetch at address 0
//   read             current PC, drives the instruction-memory address
//   instr            combinational instruction-memory data for read
//   branch_valid     redirect request (FETCH only)
//   branch_target    redirect address
//   ir, ir_pc        captured instruction and the address it came from
//   ir_valid         ir holds an unconsumed instruction
//   ir_ready         decode accepts ir this cycle
//   halted           high while in HALT
//   wrapped          sticky: PC has wrapped from all-ones to zero on a capture
//   fetch_count      saturating count of instructions captured into ir

module fetch_unit #(
    parameter int unsigned          ADDR_W    = 3,
    parameter int unsigned          INSTR_W   = 16,
    parameter logic [INSTR_W-1:0]   HALT_WORD = 16'hFFFF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ADDR_W-1:0]   read,
    input  logic [INSTR_W-1:0]  instr,
    input  logic                branch_valid,
    input  logic [ADDR_W-1:0]   branch_target,
    output logic [INSTR_W-1:0]  ir,
    output logic [ADDR_W-1:0]   ir_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic                halted,
    output logic                wrapped,
    output logic [7:0]          fetch_count
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHalt
    } state_t;

    state_t               r_state;
    state_t               w_state_d;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    w_pc_d;
    logic [INSTR_W-1:0]   r_ir;
    logic [ADDR_W-1:0]    r_ir_pc;
    logic                 r_ir_valid;
    logic                 w_ir_valid_d;
    logic                 r_wrapped;
    logic [7:0]           r_count;

    logic                 w_slot_free;
    logic                 w_start;
    logic                 w_branch;
    logic                 w_capture;
    logic                 w_is_halt;

    // Slot is free when empty or being consumed this cycle.
    assign w_slot_free = !r_ir_valid || ir_ready;
    assign w_start     = (r_state == StIdle) && start;
    // Branch outranks both capture and stall.
    assign w_branch    = (r_state == StFetch) && branch_valid;
    assign w_capture   = (r_state == StFetch) && !branch_valid && w_slot_free;
    assign w_is_halt   = (instr == HALT_WORD);

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_d = StFetch;
            StFetch: if (w_capture && w_is_halt) w_state_d = StHalt;
            StHalt:  w_state_d = StHalt;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_pc_d = r_pc;
        if (w_start) begin
            w_pc_d = '0;
        end else if (w_branch) begin
            w_pc_d = branch_target;
        end else if (w_capture) begin
            // Natural modulo-2^ADDR_W wrap, also taken on the halting capture.
            w_pc_d = r_pc + ADDR_W'(1);
        end
    end

    always_comb begin
        w_ir_valid_d = r_ir_valid;
        if (w_branch) begin
            w_ir_valid_d = 1'b0;
        end else if (w_capture) begin
            w_ir_valid_d = 1'b1;
        end else if (ir_ready) begin
            // Only reachable as a drain in HALT (or a no-op in IDLE, where valid is 0).
            w_ir_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_ir       <= '0;
            r_ir_pc    <= '0;
            r_ir_valid <= 1'b0;
            r_wrapped  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_pc       <= w_pc_d;
            r_ir_valid <= w_ir_valid_d;
            if (w_capture) begin
                r_ir    <= instr;
                r_ir_pc <= r_pc;
                if (r_pc == '1) begin
                    r_wrapped <= 1'b1;
                end
                if (r_count != 8'hFF) begin
                    r_count <= r_count + 8'd1;
                end
            end
        end
    end

    assign read        = r_pc;
    assign ir          = r_ir;
    assign ir_pc       = r_ir_pc;
    assign ir_valid    = r_ir_valid;
    assign halted      = (r_state == StHalt);
    assign wrapped     = r_wrapped;
    assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed, table-driven bench for fetch_unit.
// Memory model: word k holds 2k. Instance dut uses the default HALT_WORD,
// instance dut_h uses 16'h000A so the capture at address 5 halts it.

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        branch_valid;
    logic [2:0]  branch_target;
    logic        ir_ready;

    logic [2:0]  read,   read_h;
    logic [15:0] instr,  instr_h;
    logic [15:0] ir,     ir_h;
    logic [2:0]  ir_pc,  ir_pc_h;
    logic        ir_valid, ir_valid_h;
    logic        halted, halted_h;
    logic        wrapped, wrapped_h;
    logic [7:0]  fetch_count, fetch_count_h;

    int n_tests = 0;
    int n_fail  = 0;

    assign instr   = {12'd0, read,   1'b0};
    assign instr_h = {12'd0, read_h, 1'b0};

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .read          (read),
        .instr         (instr),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .ir_ready      (ir_ready),
        .halted        (halted),
        .wrapped       (wrapped),
        .fetch_count   (fetch_count)
    );

    fetch_unit #(
        .HALT_WORD (16'h000A)
    ) dut_h (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .read          (read_h),
        .instr         (instr_h),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .ir            (ir_h),
        .ir_pc         (ir_pc_h),
        .ir_valid      (ir_valid_h),
        .ir_ready      (ir_ready),
        .halted        (halted_h),
        .wrapped       (wrapped_h),
        .fetch_count   (fetch_count_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        ready;
        logic        bv;
        logic [2:0]  bt;
        logic        v;
        logic [15:0] ir;
        logic [2:0]  irpc;
        logic [2:0]  rd;
        logic [7:0]  cnt;
        logic        wr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic bv, input logic [2:0] bt,
                       input logic v, input logic [15:0] e_ir, input logic [2:0] e_pc,
                       input logic [2:0] e_rd, input logic [7:0] e_cnt, input logic e_wr);
        vec_t x;
        x.start = s;  x.ready = r;  x.bv = bv;  x.bt = bt;
        x.v = v;  x.ir = e_ir;  x.irpc = e_pc;  x.rd = e_rd;  x.cnt = e_cnt;  x.wr = e_wr;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start = 1'b0;  branch_valid = 1'b0;  branch_target = 3'd0;  ir_ready = 1'b0;
        #2 rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;  branch_valid = 1'b0;  branch_target = 3'd0;  ir_ready = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst read",     32'(read),        32'd0);
        chk("rst ir",       32'(ir),          32'd0);
        chk("rst ir_pc",    32'(ir_pc),       32'd0);
        chk("rst ir_valid", 32'(ir_valid),    32'd0);
        chk("rst halted",   32'(halted),      32'd0);
        chk("rst wrapped",  32'(wrapped),     32'd0);
        chk("rst count",    32'(fetch_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // start, ready, bv, bt | valid, ir, ir_pc, read, count, wrapped
        add(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 16'd0,  3'd0, 3'd0, 8'd0,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd0,  3'd0, 3'd1, 8'd1,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd2,  3'd1, 3'd2, 8'd2,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd4,  3'd2, 3'd3, 8'd3,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd6,  3'd3, 3'd4, 8'd4,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd8,  3'd4, 3'd5, 8'd5,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd10, 3'd5, 3'd6, 8'd6,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd12, 3'd6, 3'd7, 8'd7,  1'b0);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd14, 3'd7, 3'd0, 8'd8,  1'b1);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd0,  3'd0, 3'd1, 8'd9,  1'b1);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd2,  3'd1, 3'd2, 8'd10, 1'b1);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd4,  3'd2, 3'd3, 8'd11, 1'b1);
        // stall three cycles holding ir=4
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd4,  3'd2, 3'd3, 8'd11, 1'b1);
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd4,  3'd2, 3'd3, 8'd11, 1'b1);
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd4,  3'd2, 3'd3, 8'd11, 1'b1);
        add(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 16'd6,  3'd3, 3'd4, 8'd12, 1'b1);
        // stall, then branch to 5 during the stall
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd6,  3'd3, 3'd4, 8'd12, 1'b1);
        add(1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 16'd6,  3'd3, 3'd5, 8'd12, 1'b1);
        add(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 16'd10, 3'd5, 3'd6, 8'd13, 1'b1);
        // branch flushes a valid ir; start ignored while fetching
        add(1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 16'd10, 3'd5, 3'd0, 8'd13, 1'b1);
        add(1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 16'd0,  3'd0, 3'd1, 8'd14, 1'b1);

        foreach (vecs[i]) begin
            start         = vecs[i].start;
            ir_ready      = vecs[i].ready;
            branch_valid  = vecs[i].bv;
            branch_target = vecs[i].bt;
            step();
            chk($sformatf("row%0d ir_valid", i), 32'(ir_valid),    32'(vecs[i].v));
            chk($sformatf("row%0d ir", i),       32'(ir),          32'(vecs[i].ir));
            chk($sformatf("row%0d ir_pc", i),    32'(ir_pc),       32'(vecs[i].irpc));
            chk($sformatf("row%0d read", i),     32'(read),        32'(vecs[i].rd));
            chk($sformatf("row%0d count", i),    32'(fetch_count), 32'(vecs[i].cnt));
            chk($sformatf("row%0d wrapped", i),  32'(wrapped),     32'(vecs[i].wr));
            chk($sformatf("row%0d halted", i),   32'(halted),      32'd0);
        end

        // Halt sequence on dut_h, including a branch to 0 that must not set wrapped.
        do_reset();
        start = 1'b1;  ir_ready = 1'b1;
        step();
        start = 1'b0;  branch_valid = 1'b1;  branch_target = 3'd0;
        step();
        chk("h br0 wrapped",  32'(wrapped_h),  32'd0);
        chk("h br0 read",     32'(read_h),     32'd0);
        chk("h br0 ir_valid", 32'(ir_valid_h), 32'd0);
        branch_valid = 1'b0;
        repeat (5) step();
        chk("h pre halted",   32'(halted_h),   32'd0);
        step();
        chk("h halted",       32'(halted_h),      32'd1);
        chk("h ir",           32'(ir_h),          32'h000A);
        chk("h ir_pc",        32'(ir_pc_h),       32'd5);
        chk("h read",         32'(read_h),        32'd6);
        chk("h ir_valid",     32'(ir_valid_h),    32'd1);
        chk("h count",        32'(fetch_count_h), 32'd6);
        ir_ready = 1'b0;  branch_valid = 1'b1;  branch_target = 3'd2;  start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("h hold%0d halted", k), 32'(halted_h),      32'd1);
            chk($sformatf("h hold%0d read", k),   32'(read_h),        32'd6);
            chk($sformatf("h hold%0d valid", k),  32'(ir_valid_h),    32'd1);
            chk($sformatf("h hold%0d count", k),  32'(fetch_count_h), 32'd6);
        end
        ir_ready = 1'b1;  branch_valid = 1'b0;  start = 1'b0;
        step();
        chk("h drain valid",  32'(ir_valid_h), 32'd0);
        step();
        chk("h after valid",  32'(ir_valid_h), 32'd0);
        chk("h after read",   32'(read_h),     32'd6);
        chk("h after halted", 32'(halted_h),   32'd1);
        chk("dflt not halted", 32'(halted),    32'd0);

        // Saturation of fetch_count.
        do_reset();
        start = 1'b1;  ir_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (300) step();
        chk("sat count",   32'(fetch_count), 32'd255);
        chk("sat wrapped", 32'(wrapped),     32'd1);

        // Asynchronous reset mid-fetch.
        do_reset();
        start = 1'b1;  ir_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("ar pre valid", 32'(ir_valid), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("ar read",     32'(read),        32'd0);
        chk("ar ir",       32'(ir),          32'd0);
        chk("ar ir_pc",    32'(ir_pc),       32'd0);
        chk("ar ir_valid", 32'(ir_valid),    32'd0);
        chk("ar halted",   32'(halted),      32'd0);
        chk("ar wrapped",  32'(wrapped),     32'd0);
        chk("ar count",    32'(fetch_count), 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("ar idle%0d valid", k), 32'(ir_valid), 32'd0);
            chk($sformatf("ar idle%0d read", k),  32'(read),     32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
